pong_match_ctrl: RTL and testbench

Match sequencer for the pong game. It sits between `vga_sync` and `pong_logic` in `pong_engine_top`. It derives a once-per-frame tick from `v_sync` and runs the serve / play / point / game-over state machine. It gates ball motion in `pong_logic` through `game_run` and `ball_reset`, keeps both players' scores, and exposes scores and status to `pong_renderer`.

---
 rtl/pong_match_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_pong_match_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match sequencer for the pong game.
// Derives a once-per-frame tick from v_sync, runs the
// IDLE / SERVE / PLAY / POINT / OVER state machine, keeps both
// scores and gates ball motion in pong_logic via game_run/ball_reset.
module pong_match_ctrl #(
  parameter int WIN_SCORE    = 7,   // 1..15
  parameter int SERVE_FRAMES = 60,  // 1..255
  parameter int POINT_FRAMES = 30   // 1..255
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic       v_sync,
  input  logic       start_btn,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       frame_tick,
  output logic       game_run,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);

  // State encodings are visible on the state port, so they are fixed.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_POINT = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES);
  localparam logic [7:0] POINT_LOAD = 8'(POINT_FRAMES);
  localparam logic [3:0] WIN_VAL    = 4'(WIN_SCORE);

  // Input conditioning registers.
  logic       vs_q;
  logic       start_q;
  logic       tick_q;
  logic       tick_d;
  logic       start_edge;

  // Match state.
  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] score1_q, score1_d;
  logic [3:0] score2_q, score2_d;
  logic       dir_q, dir_d;
  logic       winner_q, winner_d;

  // Registered outputs derived from the next state.
  logic       run_q, run_d;
  logic       ball_reset_q, ball_reset_d;
  logic       over_q, over_d;

  // Incremented scores, used both for the update and the win compare.
  logic [3:0] score1_inc;
  logic [3:0] score2_inc;

  assign score1_inc = score1_q + 4'd1;
  assign score2_inc = score2_q + 4'd1;

  // Falling edge of v_sync (active-low pulse) and rising edge of start.
  // Both compare the live input against its one-cycle-old sample, so a
  // triggering input acts on the same edge that samples it.
  assign tick_d     = vs_q & ~v_sync;
  assign start_edge = start_btn & ~start_q;

  // Sample v_sync/start_btn and register the frame tick. The samples
  // reset high so a held-low v_sync or held-high start does not fire.
  always_ff @(posedge clk_0) begin
    if (rst) begin
      vs_q    <= 1'b1;
      start_q <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      vs_q    <= v_sync;
      start_q <= start_btn;
      tick_q  <= tick_d;
    end
  end

  // State register and all registered match outputs.
  always_ff @(posedge clk_0) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      score1_q     <= 4'd0;
      score2_q     <= 4'd0;
      dir_q        <= 1'b1;
      winner_q     <= 1'b0;
      run_q        <= 1'b0;
      ball_reset_q <= 1'b0;
      over_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      dir_q        <= dir_d;
      winner_q     <= winner_d;
      run_q        <= run_d;
      ball_reset_q <= ball_reset_d;
      over_q       <= over_d;
    end
  end

  // Next-state logic: transitions, countdown, scoring.
  // The countdown only advances on the registered frame tick, so a tick
  // seen on frame_tick takes effect on the following edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    score1_d = score1_q;
    score2_d = score2_q;
    dir_d    = dir_q;
    winner_d = winner_q;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_edge) begin
          score1_d = 4'd0;
          score2_d = 4'd0;
          dir_d    = 1'b1;
          cnt_d    = SERVE_LOAD;
          state_d  = ST_SERVE;
        end
      end

      ST_SERVE: begin
        if (tick_q) begin
          if (cnt_q == 8'd1) begin
            state_d = ST_PLAY;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end

      ST_PLAY: begin
        // miss_left has priority; a simultaneous miss_right is dropped.
        if (miss_left) begin
          score2_d = score2_inc;
          dir_d    = 1'b0;
          if (score2_inc == WIN_VAL) begin
            winner_d = 1'b1;
            state_d  = ST_OVER;
          end else begin
            cnt_d   = POINT_LOAD;
            state_d = ST_POINT;
          end
        end else if (miss_right) begin
          score1_d = score1_inc;
          dir_d    = 1'b1;
          if (score1_inc == WIN_VAL) begin
            winner_d = 1'b0;
            state_d  = ST_OVER;
          end else begin
            cnt_d   = POINT_LOAD;
            state_d = ST_POINT;
          end
        end
      end

      ST_POINT: begin
        if (tick_q) begin
          if (cnt_q == 8'd1) begin
            cnt_d   = SERVE_LOAD;
            state_d = ST_SERVE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end

      default: begin
        // Encodings 5..7 cannot be reached; recover to IDLE.
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: registered flags follow the state being entered.
  // ball_reset fires on every entry into SERVE, which covers both the
  // start edge and the end of a POINT, and lasts exactly one cycle.
  always_comb begin
    run_d        = 1'b0;
    over_d       = 1'b0;
    ball_reset_d = 1'b0;
    if (state_d == ST_PLAY) begin
      run_d = 1'b1;
    end
    if (state_d == ST_OVER) begin
      over_d = 1'b1;
    end
    if ((state_d == ST_SERVE) && (state_q != ST_SERVE)) begin
      ball_reset_d = 1'b1;
    end
  end

  assign frame_tick = tick_q;
  assign game_run   = run_q;
  assign ball_reset = ball_reset_q;
  assign serve_dir  = dir_q;
  assign score1     = score1_q;
  assign score2     = score2_q;
  assign game_over  = over_q;
  assign winner     = winner_q;
  assign state      = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Testbench for pong_match_ctrl: directed match scenarios followed by
// randomized play, with a per-cycle scoreboard fed by a reference model.
module tb_pong_match_ctrl;

  localparam int WIN = 3;
  localparam int SF  = 3;
  localparam int PF  = 2;

  logic       clk_0 = 1'b0;
  logic       rst = 1'b1;
  logic       v_sync = 1'b0;
  logic       start_btn = 1'b1;
  logic       miss_left = 1'b0;
  logic       miss_right = 1'b0;
  logic       frame_tick, game_run, ball_reset, serve_dir;
  logic [3:0] score1, score2;
  logic       game_over, winner;
  logic [2:0] state;

  pong_match_ctrl #(
    .WIN_SCORE(WIN), .SERVE_FRAMES(SF), .POINT_FRAMES(PF)
  ) dut (
    .clk_0(clk_0), .rst(rst), .v_sync(v_sync), .start_btn(start_btn),
    .miss_left(miss_left), .miss_right(miss_right),
    .frame_tick(frame_tick), .game_run(game_run), .ball_reset(ball_reset),
    .serve_dir(serve_dir), .score1(score1), .score2(score2),
    .game_over(game_over), .winner(winner), .state(state)
  );

  always #5 clk_0 = ~clk_0;

  typedef struct packed {
    logic       tick;
    logic       run;
    logic       br;
    logic       dir;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       go;
    logic       win;
    logic [2:0] st;
  } outs_t;

  outs_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc_no   = 0;

  // Reference model: game described as "what happened this frame/cycle".
  int m_state = 0;
  int m_cnt = 0;
  int m_s1 = 0, m_s2 = 0;
  bit m_dir = 1, m_win = 0;
  bit m_vs_prev = 1, m_start_prev = 1, m_tick = 0;
  int last_state = -1;

  task automatic model_step(input bit r, input bit vs, input bit st,
                            input bit ml, input bit mr, output outs_t e);
    bit tick_now, sedge, br;
    br = 0;
    if (r) begin
      m_state = 0; m_cnt = 0; m_s1 = 0; m_s2 = 0;
      m_dir = 1; m_win = 0; m_vs_prev = 1; m_start_prev = 1; m_tick = 0;
    end else begin
      tick_now = m_vs_prev && !vs;
      sedge    = !m_start_prev && st;
      if ((m_state == 0 || m_state == 4) && sedge) begin
        m_s1 = 0; m_s2 = 0; m_dir = 1; br = 1; m_cnt = SF; m_state = 1;
      end else if (m_state == 1 && m_tick) begin
        if (m_cnt == 1) m_state = 2;
        else m_cnt = m_cnt - 1;
      end else if (m_state == 2 && ml) begin
        m_s2 = m_s2 + 1; m_dir = 0;
        if (m_s2 == WIN) begin m_state = 4; m_win = 1; end
        else begin m_cnt = PF; m_state = 3; end
      end else if (m_state == 2 && mr) begin
        m_s1 = m_s1 + 1; m_dir = 1;
        if (m_s1 == WIN) begin m_state = 4; m_win = 0; end
        else begin m_cnt = PF; m_state = 3; end
      end else if (m_state == 3 && m_tick) begin
        if (m_cnt == 1) begin br = 1; m_cnt = SF; m_state = 1; end
        else m_cnt = m_cnt - 1;
      end
      m_tick = tick_now;
      m_vs_prev = vs;
      m_start_prev = st;
    end
    e.tick = m_tick;
    e.run  = (m_state == 2);
    e.br   = br;
    e.dir  = m_dir;
    e.s1   = 4'(m_s1);
    e.s2   = 4'(m_s2);
    e.go   = (m_state == 4);
    e.win  = m_win;
    e.st   = 3'(m_state);
  endtask

  // Monitor: every clock edge the DUT presents a new output vector.
  always @(posedge clk_0) begin
    outs_t e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {frame_tick, game_run, ball_reset, serve_dir, score1, score2,
           game_over, winner, state};
      // winner is only meaningful while game_over is high
      if (!e.go) begin
        e.win = 1'b0;
        a.win = 1'b0;
      end
      n_checks++;
      if (a === e) n_pass++;
      else
        $display("FAIL cycle %0d outputs: got tick=%b run=%b br=%b dir=%b s1=%0d s2=%0d over=%b win=%b st=%0d, expected tick=%b run=%b br=%b dir=%b s1=%0d s2=%0d over=%b win=%b st=%0d",
                 cyc_no, a.tick, a.run, a.br, a.dir, a.s1, a.s2, a.go, a.win, a.st,
                 e.tick, e.run, e.br, e.dir, e.s1, e.s2, e.go, e.win, e.st);
    end
  end

  // v_sync generator: 2 cycles low per frame, random frame length.
  int phase = 2;
  int flen = 8;
  function automatic bit next_vs();
    bit v;
    v = !(phase < 2);
    phase++;
    if (phase >= flen) begin
      phase = 0;
      flen = $urandom_range(6, 12);
    end
    return v;
  endfunction

  bit start_lvl = 1;

  task automatic drive(input bit r, input bit vs, input bit st,
                       input bit ml, input bit mr);
    outs_t e;
    @(negedge clk_0);
    rst = r; v_sync = vs; start_btn = st; miss_left = ml; miss_right = mr;
    start_lvl = st;
    model_step(r, vs, st, ml, mr, e);
    exp_q.push_back(e);
    cyc_no++;
    if (m_state != last_state) begin
      $display("cycle %0d: state %0d -> %0d score %0d-%0d br=%b",
               cyc_no, last_state, m_state, m_s1, m_s2, e.br);
      last_state = m_state;
    end
  endtask

  task automatic go(input bit r, input bit st, input bit ml, input bit mr);
    drive(r, next_vs(), st, ml, mr);
  endtask

  // Idle play until the model reaches the target state, within a budget.
  task automatic run_until(input int target, input string what);
    int k;
    k = 0;
    while (m_state != target && k < 300) begin
      go(0, start_lvl, 0, 0);
      k++;
    end
    n_checks++;
    if (m_state == target) n_pass++;
    else $display("FAIL wait %s: state %0d after %0d cycles, required %0d",
                  what, m_state, k, target);
  endtask

  initial begin
    // Reset held with v_sync low and start high: no tick, no start.
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 0, 0);
    drive(0, 1, 1, 0, 0);
    phase = 2; flen = 8;
    go(0, 0, 0, 0);
    go(0, 1, 0, 0);          // start edge -> SERVE with ball_reset
    run_until(2, "serve->play");
    go(0, 1, 1, 0);          // miss_left: 0-1, POINT
    run_until(1, "point->serve");
    go(0, 1, 1, 0);          // miss_left ignored in SERVE
    run_until(2, "serve->play 2");
    go(0, 1, 1, 1);          // simultaneous: miss_left wins, 0-2
    for (int p = 0; p < 3; p++) begin
      run_until(2, "to play");
      go(0, 1, 0, 1);        // player 1 scores
    end
    go(0, 1, 0, 0);
    go(0, 0, 0, 0);
    go(0, 1, 0, 0);          // start edge from OVER
    run_until(2, "restart play");
    go(0, 1, 0, 1);
    run_until(2, "play 1-0");
    go(0, 1, 0, 1);
    run_until(2, "play 2-0");
    go(0, 1, 1, 0);
    run_until(2, "play 2-1");
    go(1, 1, 0, 1);          // reset wins over the scoring pulse
    for (int i = 0; i < 4; i++) go(0, 1, 0, 0);

    // Randomized play.
    for (int i = 0; i < 4000; i++) begin
      bit s, ml, mr, r;
      s  = start_lvl;
      if ($urandom_range(0, 11) == 0) s = !s;
      ml = ($urandom_range(0, 5) == 0);
      mr = ($urandom_range(0, 5) == 0);
      r  = ($urandom_range(0, 399) == 0);
      go(r, s, ml, mr);
    end

    @(posedge clk_0);
    #3;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard drain: %0d left, required 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
